i2c_master_arbiter: RTL
=======================

# i2c_master_arbiter

Round-robin arbiter and transaction sequencer that shares one I2C master among `NUM_REQ` requesters. It sits between the requesting client blocks and the master's `enable`/`rw`/`ready` control interface. For each granted requester it launches exactly one master transaction, tracks it to completion, and returns a one-cycle `done` pulse. An optional watchdog flags a master that never starts or never finishes.

## Interface
- `NUM_REQ`, 4 — number of requesters, 2..8.
- `GAP_CYCLES`, 8 — idle `clk` cycles enforced between transactions; 0 = no gap.
- `LAUNCH_TIMEOUT`, 64 — max cycles in LAUNCH with `m_ready` still high (watchdog build only); < 65536.
- `BUSY_TIMEOUT`, 4096 — max cycles in BUSY with `m_ready` still low (watchdog build only); < 65536.

Ports:
- `clk` in 1 — system clock; also the clock feeding the master's divider.
- `rst` in 1 — synchronous, active-high reset.
- `req` in NUM_REQ — per-requester transaction request, level.
- `req_rw` in NUM_REQ — per-requester direction: 0 = write, 1 = read.
- `grant` out NUM_REQ — one-hot; high for the whole owned transaction.
- `done` out NUM_REQ — one-cycle pulse to the owner at completion.
- `err` out 1 — one-cycle pulse, coincident with `done`, on watchdog abort.
- `m_enable` out 1 — master enable.
- `m_rw` out 1 — master direction.
- `m_ready` in 1 — master idle indication.

## Operation
- All outputs are registered.
- Reset values: `grant`=0, `done`=0, `err`=0, `m_enable`=0, `m_rw`=0, state=IDLE, priority pointer=0 (requester 0 highest).
- States: IDLE, LAUNCH, BUSY, DONE, GAP.
- **IDLE**: when `m_ready`=1 and `req`≠0, pick the first set bit searching upward from the pointer, with wrap.
  - Set `grant[i]`, `m_rw`=`req_rw[i]`, `m_enable`=1; move pointer to i+1 mod NUM_REQ; go to LAUNCH.
  - If `m_ready`=0, grant nothing.
- **LAUNCH**: hold `m_enable`=1 until `m_ready` is sampled 0, then `m_enable`=0 and go to BUSY.
  - `m_rw` stays stable from grant until DONE.
- **BUSY**: wait for `m_ready` sampled 1, then go to DONE.
- **DONE**: for one cycle, `done[i]`=1 and `grant` clears in the same cycle. Then go to GAP, or to IDLE if `GAP_CYCLES`=0.
- **GAP**: count `GAP_CYCLES` cycles with no grant, then go to IDLE.
- `req`/`req_rw` are sampled only at the IDLE grant decision.
  - Dropping `req[i]` after grant does not abort the transaction.
  - A `req[i]` still high after its `done` competes again, with lowest priority.
- Requests arriving mid-transaction wait; no request is lost while it is held.
- `rst` mid-transaction: all outputs return to reset values on that edge and the pointer returns to 0. No `done` is issued for the aborted transaction.

## Timing
- Grant latency: `req` sampled high in IDLE → `grant`/`m_enable` high on the next edge.
- `m_enable` stays high across multiple `clk` cycles until `m_ready` falls. The master samples on a divided clock, so `m_enable` width is not fixed.
- `done` is asserted 1 cycle after `m_ready` is sampled high in BUSY.
- Back-to-back throughput: the next grant comes GAP_CYCLES+1 cycles after `done`.
- Simultaneous requests: strict round-robin from the pointer. With all requests held, ownership rotates 0,1,2,3,0…

## Configuration
- Macro: `I2C_ARB_WATCHDOG_EN`.
- Defined: a 16-bit counter clears on each state entry and increments in LAUNCH and BUSY.
  - LAUNCH exceeding `LAUNCH_TIMEOUT`, or BUSY exceeding `BUSY_TIMEOUT`: drop `m_enable` and go to DONE with `err`=1 alongside `done[i]`.
- Undefined: no counter; LAUNCH and BUSY wait indefinitely; `err` is tied to 0.

## Test plan
- **Reset**: after `rst` held 2 cycles, all outputs are 0. `req`=4'b0100 with `m_ready`=1 → `grant`=4'b0100, `m_rw`=`req_rw[2]`, `m_enable`=1 on the next edge.
- **Full handshake**: master model drops `m_ready` 5 cycles after `m_enable`.
  - `m_enable` is 0 the cycle after `m_ready` is sampled low.
  - `m_ready` high after 40 cycles → `done[2]` pulses for exactly 1 cycle, `grant`=0.
- **Round-robin**: `req`=4'b1111 held, `GAP_CYCLES`=8 → grant order 0,1,2,3,0; each next grant 9 cycles after the previous `done`.
- **Master busy**: `m_ready`=0 in IDLE with `req`=4'b0001 → no grant until `m_ready`=1.
- **Mid-transaction reset**: `rst` asserted in BUSY → `grant`=0 and `m_enable`=0 next edge; no `done`. Next `req`=4'b1010 grants requester 1.
- **Watchdog** (`I2C_ARB_WATCHDOG_EN`, `LAUNCH_TIMEOUT`=64): `m_ready` stuck at 1 → `err` and `done[i]` pulse together 65 cycles after grant, and `m_enable`=0.

Source files
------------

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter and sequencer sharing one I2C master among NUM_REQ clients.
// Optional launch/busy watchdog enabled by defining I2C_ARB_WATCHDOG_EN.
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 8,
  parameter int LAUNCH_TIMEOUT = 64,
  parameter int BUSY_TIMEOUT   = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_rw,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               err,
  output logic               m_enable,
  output logic               m_rw,
  input  logic               m_ready
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, BUSY, DONE, GAP
  } state_t;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 2) ? GAP_CYCLES - 2 : 0);
  localparam bit USE_GAP = (GAP_CYCLES >= 2);

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic               men_q, men_d;
  logic               mrw_q, mrw_d;
  logic [GW-1:0]      gap_q, gap_d;

  logic               found;
  logic [PW-1:0]      pick;
  logic [PW:0]        idx;
  logic [PW:0]        pick_inc;
  logic [PW-1:0]      ptr_inc;
  logic [NUM_REQ-1:0] pick_oh;
  logic               launch_to;
  logic               busy_to;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= NR) idx = idx - NR;
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
    pick_inc      = {1'b0, pick} + (PW+1)'(1);
    ptr_inc       = (pick_inc == NR) ? '0 : pick_inc[PW-1:0];
  end

`ifdef I2C_ARB_WATCHDOG_EN
  localparam logic [15:0] LTO = 16'(LAUNCH_TIMEOUT);
  localparam logic [15:0] BTO = 16'(BUSY_TIMEOUT);
  logic [15:0] wd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else if (state_d != state_q) begin
      wd_q <= '0;
    end else if (state_q == LAUNCH || state_q == BUSY) begin
      wd_q <= wd_q + 16'd1;
    end
  end

  assign launch_to = (state_q == LAUNCH) && (wd_q >= LTO);
  assign busy_to   = (state_q == BUSY) && (wd_q >= BTO);
`else
  logic [31:0] unused_to;
  assign unused_to = 32'(LAUNCH_TIMEOUT) ^ 32'(BUSY_TIMEOUT);
  assign launch_to = 1'b0;
  assign busy_to   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = 1'b0;
    men_d   = men_q;
    mrw_d   = mrw_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (m_ready && found) begin
          grant_d = pick_oh;
          mrw_d   = req_rw[pick];
          men_d   = 1'b1;
          ptr_d   = ptr_inc;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!m_ready) begin
          men_d   = 1'b0;
          state_d = BUSY;
        end else if (launch_to) begin
          men_d   = 1'b0;
          done_d  = grant_q;
          err_d   = 1'b1;
          grant_d = '0;
          state_d = DONE;
        end
      end
      BUSY: begin
        if (m_ready || busy_to) begin
          done_d  = grant_q;
          err_d   = !m_ready;
          men_d   = 1'b0;
          grant_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        gap_d   = '0;
        state_d = USE_GAP ? GAP : IDLE;
      end
      GAP: begin
        // DONE and the IDLE decision cycle complete the idle gap.
        gap_d = gap_q + GW'(1);
        if (gap_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      men_q   <= 1'b0;
      mrw_q   <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      men_q   <= men_d;
      mrw_q   <= mrw_d;
      gap_q   <= gap_d;
    end
  end

  assign grant    = grant_q;
  assign done     = done_q;
  assign err      = err_q;
  assign m_enable = men_q;
  assign m_rw     = mrw_q;

endmodule
